// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter: one registered broadcast per cycle from NUM_FU channels.
// Optional statistics counters are enabled with `define CDB_STATS_EN.
module cdb_arbiter #(
   parameter int unsigned NUM_FU   = 4,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ROB_IX_W = 3,
   parameter int unsigned FU_ID_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_FU-1:0]            fu_valid_in,
   input  logic [NUM_FU*DATA_W-1:0]     fu_data_in,
   input  logic [NUM_FU*ROB_IX_W-1:0]   fu_rob_ix_in,
   output logic [NUM_FU-1:0]            fu_read_out,
   input  logic                         flush_in,
   output logic                         cdb_valid_out,
   output logic [DATA_W-1:0]            cdb_value_out,
   output logic [ROB_IX_W-1:0]          cdb_rob_ix_out,
`ifdef CDB_STATS_EN
   output logic [15:0]                  stat_bcast_out,
   output logic [15:0]                  stat_conflict_out,
`endif
   output logic [FU_ID_W-1:0]           cdb_fu_id_out
);

   logic [DATA_W-1:0]   data_arr [NUM_FU];
   logic [ROB_IX_W-1:0] rob_arr  [NUM_FU];
   logic [FU_ID_W-1:0]  rr_ptr;
   logic [FU_ID_W-1:0]  grant_id;
   logic                grant_any;
   logic [31:0]         scan_ch;
   logic [FU_ID_W-1:0]  scan_id;

   for (genvar k = 0; k < NUM_FU; k++) begin : g_unpack
      assign data_arr[k] = fu_data_in[k*DATA_W +: DATA_W];
      assign rob_arr[k]  = fu_rob_ix_in[k*ROB_IX_W +: ROB_IX_W];
   end

   // Scan from rr_ptr upward with wrap; the first valid channel wins.
   always_comb begin
      grant_any   = 1'b0;
      grant_id    = '0;
      scan_ch     = '0;
      scan_id     = '0;
      fu_read_out = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         scan_ch = (32'(rr_ptr) + i) % NUM_FU;
         scan_id = FU_ID_W'(scan_ch);
         if (!grant_any && fu_valid_in[scan_id]) begin
            grant_any = 1'b1;
            grant_id  = scan_id;
         end
      end
      if (flush_in || rst_in) begin
         grant_any = 1'b0;
      end
      if (grant_any) begin
         fu_read_out[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cdb_valid_out  <= 1'b0;
         cdb_value_out  <= '0;
         cdb_rob_ix_out <= '0;
         cdb_fu_id_out  <= '0;
         rr_ptr         <= '0;
      end else begin
         cdb_valid_out <= grant_any;
         if (grant_any) begin
            cdb_value_out  <= data_arr[grant_id];
            cdb_rob_ix_out <= rob_arr[grant_id];
            cdb_fu_id_out  <= grant_id;
            rr_ptr         <= (grant_id == FU_ID_W'(NUM_FU - 1)) ? '0 : grant_id + FU_ID_W'(1);
         end
      end
   end

`ifdef CDB_STATS_EN
   logic [15:0] stat_bcast_q;
   logic [15:0] stat_conflict_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stat_bcast_q    <= '0;
         stat_conflict_q <= '0;
      end else begin
         if (grant_any && (stat_bcast_q != '1)) begin
            stat_bcast_q <= stat_bcast_q + 16'd1;
         end
         if (!flush_in && ($countones(fu_valid_in) >= 2) && (stat_conflict_q != '1)) begin
            stat_conflict_q <= stat_conflict_q + 16'd1;
         end
      end
   end

   assign stat_bcast_out    = stat_bcast_q;
   assign stat_conflict_out = stat_conflict_q;
`endif

endmodule
